ddr2_host_request_packer: RTL and testbench
===========================================

# ddr2_host_request_packer

Host-side front end for the DDR2 controller. It accepts single-burst read/write requests from the host, pushes the BL write-data words into the DATA FIFO, and then pushes one 34-bit command word into the CMD FIFO. Both FIFOs are drained by the controller's processing logic. Data always precedes its write command, so the controller never fetches a write command whose burst data is incomplete.

## Interface
- BL, 8, write burst length in 16-bit words (fixed 8 for this controller)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- host_valid  in  1  request present
- host_ready  out  1  request accepted when host_valid && host_ready
- host_cmd  in  3  001 = SCR (scalar read), 010 = SCW (scalar write); all other codes invalid
- host_addr  in  26  {BA[2:0], row[12:0], col[9:0]}
- host_wdata  in  16  write-data beat
- host_wvalid  in  1  beat present
- host_wready  out  1  beat accepted when host_wvalid && host_wready
- CMD_put  out  1  CMD FIFO write strobe
- CMD_data_in  out  34  {cmd[2:0], addr[25:0], tag[4:0]}
- CMD_full  in  1  CMD FIFO full
- DATA_put  out  1  DATA FIFO write strobe
- DATA_data_in  out  16  DATA FIFO write data
- DATA_full  in  1  DATA FIFO full
- cmd_err  out  1  one-cycle pulse on an invalid host_cmd
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, WDATA, PUSH, ERR.
- IDLE
  - host_ready = !CMD_full.
  - On accept, latch host_cmd and host_addr.
  - SCW → WDATA with beat counter = 0.
  - SCR → PUSH.
  - Invalid code → ERR.
- WDATA
  - host_wready = !DATA_full.
  - DATA_put = host_wvalid && host_wready (combinational); DATA_data_in = host_wdata.
  - Each accepted beat increments the 3-bit beat counter.
  - On the accepted beat where counter == BL-1 → PUSH.
  - host_ready = 0.
- PUSH
  - CMD_put = !CMD_full (combinational).
  - CMD_data_in = {latched cmd, latched addr, tag}.
  - The cycle CMD_put is high: tag <= tag+1 (5-bit, wraps 31→0) and state → IDLE.
  - While CMD_full is high, stay in PUSH with CMD_put = 0.
- ERR
  - cmd_err = 1 for exactly one cycle, then → IDLE.
  - Nothing is pushed and tag is unchanged.
- Strobe gating:
  - DATA_put is 0 outside WDATA; CMD_put is 0 outside PUSH.
  - FULL inputs gate the strobes combinationally, so a full FIFO is never written.
- host_wvalid outside WDATA is ignored (host_wready = 0).
- Reset mid-operation returns to IDLE. Words already written to the DATA FIFO are not retracted; the system reset also clears the FIFOs.

## Timing
- Reset values:
  - state IDLE, beat counter 0, tag 0.
  - host_ready, host_wready, CMD_put, DATA_put, cmd_err, busy all 0.
  - CMD_data_in and DATA_data_in are 0.
  - All combinational outputs are forced to 0 while reset is high.
- SCR latency: accept at cycle N, CMD_put at N+1 if CMD_full = 0.
- SCW latency:
  - Accept at N; first beat can be accepted at N+1.
  - With no stalls, beats occupy N+1..N+8 and CMD_put occurs at N+9.
- Throughput:
  - Back-to-back SCR: one command every 2 cycles (IDLE, PUSH).
  - SCW: one command every BL+2 cycles.
- Simultaneous events:
  - DATA_full rising mid-burst stalls beats with no loss; the beat counter holds.
  - CMD_full high in IDLE blocks acceptance. CMD_full high in PUSH holds the latched command.

## Test plan
- Reset, then SCR with addr = 26'h2A5_5A5A → CMD_put one cycle later with CMD_data_in = {3'b001, 26'h2A55A5A, 5'd0}; DATA_put never asserted; tag becomes 1.
- SCW with 8 consecutive beats 16'h1000..16'h1007 → DATA_put on 8 consecutive cycles carrying those values in order, then exactly one CMD_put with cmd = 010.
- SCW with DATA_full forced high during beats 3–5 → host_wready low while DATA_full is high, no DATA_put, the remaining beats resume in order, and the total is exactly 8 DATA_put.
- CMD_full held high for 10 cycles in PUSH → CMD_put = 0 throughout; the command is pushed the cycle after CMD_full drops, with unchanged contents.
- host_cmd = 3'b101 → accepted; cmd_err pulses once; no FIFO writes; tag unchanged; the next SCR carries the old tag.
- 33 SCR commands → tags run 0..31 then 0; reset asserted during WDATA after 4 beats → all outputs 0 and state IDLE the following cycle.

Source files
------------

// File: rtl/ddr2_host_request_packer_if.sv
// Host request / FIFO-side bundle for ddr2_host_request_packer.
//   host_valid/host_ready/host_cmd/host_addr : request handshake (host -> packer)
//   host_wdata/host_wvalid/host_wready       : write-data beat handshake
//   CMD_put/CMD_data_in/CMD_full             : CMD FIFO write side
//   DATA_put/DATA_data_in/DATA_full          : DATA FIFO write side
//   cmd_err, busy                            : status
// slave = the packer, master = the host/FIFO environment.
interface ddr2_host_request_packer_if;
    logic        host_valid;
    logic        host_ready;
    logic [2:0]  host_cmd;
    logic [25:0] host_addr;
    logic [15:0] host_wdata;
    logic        host_wvalid;
    logic        host_wready;
    logic        CMD_put;
    logic [33:0] CMD_data_in;
    logic        CMD_full;
    logic        DATA_put;
    logic [15:0] DATA_data_in;
    logic        DATA_full;
    logic        cmd_err;
    logic        busy;

    modport slave (
        input  host_valid, host_cmd, host_addr, host_wdata, host_wvalid,
               CMD_full, DATA_full,
        output host_ready, host_wready, CMD_put, CMD_data_in,
               DATA_put, DATA_data_in, cmd_err, busy
    );

    modport master (
        output host_valid, host_cmd, host_addr, host_wdata, host_wvalid,
               CMD_full, DATA_full,
        input  host_ready, host_wready, CMD_put, CMD_data_in,
               DATA_put, DATA_data_in, cmd_err, busy
    );
endinterface

// File: rtl/ddr2_host_request_packer.sv
// Host-side request packer for the DDR2 controller.
// Accepts one read (SCR) or write (SCW) request at a time. For a write, the
// BL data beats are streamed into the DATA FIFO first, then one 34-bit
// command word {cmd, addr, tag} is pushed into the CMD FIFO, so the
// controller never sees a write command before its data is complete.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : ddr2_host_request_packer_if.slave (host + FIFO signals)
module ddr2_host_request_packer #(
    parameter int unsigned BL = 8
) (
    input  logic clk,
    input  logic reset,
    ddr2_host_request_packer_if.slave bus
);

    localparam logic [2:0] CMD_SCR = 3'b001;
    localparam logic [2:0] CMD_SCW = 3'b010;
    localparam logic [2:0] LAST_BEAT = 3'(BL - 1);

    typedef enum logic [1:0] {IDLE, WDATA, PUSH, ERR} state_t;

    state_t      state;
    logic [2:0]  beat_cnt;
    logic [4:0]  tag;
    logic [2:0]  cmd_q;
    logic [25:0] addr_q;
    logic        cmd_err_q;
    logic        busy_q;

    logic req_acc;
    logic beat_acc;
    logic cmd_push;

    // Handshakes and strobes are combinational so a FULL flag blocks the
    // write in the same cycle; everything is forced low while reset is high.
    always_comb begin
        bus.host_ready   = 1'b0;
        bus.host_wready  = 1'b0;
        bus.DATA_put     = 1'b0;
        bus.DATA_data_in = '0;
        bus.CMD_put      = 1'b0;
        bus.CMD_data_in  = '0;
        bus.cmd_err      = 1'b0;
        bus.busy         = 1'b0;
        if (!reset) begin
            bus.host_ready  = (state == IDLE) && !bus.CMD_full;
            bus.host_wready = (state == WDATA) && !bus.DATA_full;
            bus.DATA_put    = bus.host_wready && bus.host_wvalid;
            if (state == WDATA) begin
                bus.DATA_data_in = bus.host_wdata;
            end
            bus.CMD_put     = (state == PUSH) && !bus.CMD_full;
            bus.CMD_data_in = {cmd_q, addr_q, tag};
            bus.cmd_err     = cmd_err_q;
            bus.busy        = busy_q;
        end
    end

    assign req_acc  = bus.host_valid && bus.host_ready;
    assign beat_acc = bus.DATA_put;
    assign cmd_push = bus.CMD_put;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            tag       <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            cmd_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cmd_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_acc) begin
                        cmd_q  <= bus.host_cmd;
                        addr_q <= bus.host_addr;
                        busy_q <= 1'b1;
                        case (bus.host_cmd)
                            CMD_SCW: begin
                                state    <= WDATA;
                                beat_cnt <= '0;
                            end
                            CMD_SCR: state <= PUSH;
                            default: begin
                                state     <= ERR;
                                cmd_err_q <= 1'b1;
                            end
                        endcase
                    end
                end
                WDATA: begin
                    if (beat_acc) begin
                        beat_cnt <= beat_cnt + 3'd1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= PUSH;
                        end
                    end
                end
                PUSH: begin
                    if (cmd_push) begin
                        tag    <= tag + 5'd1;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                ERR: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_host_request_packer.sv
// Bench for ddr2_host_request_packer: a reset check, a vector table,
// hand-written corner sequences and a randomized phase. Every FIFO write
// and error pulse is matched against an expected-event queue filled from
// the request-level rules (data beats, then the tagged command word).
module tb_ddr2_host_request_packer;

    logic clk;
    logic reset;
    ddr2_host_request_packer_if bus ();

    ddr2_host_request_packer #(.BL(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;   // 0 data word, 1 command word, 2 error pulse
        logic [33:0] val;
    } ev_t;

    typedef struct {
        logic [2:0]  cmd;
        logic [25:0] addr;
        bit          exp_cmd_put;
        bit          exp_err;
        bit          exp_wready;
        logic [33:0] exp_word;
    } vec_t;

    ev_t         expq[$];
    logic [15:0] beats [8];
    vec_t        vt [8];
    int          total = 0;
    int          bad = 0;
    int          data_puts = 0;
    int          model_tag = 0;
    bit          rand_full = 0;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Negedge sample point: every FIFO write / error pulse consumes one event.
    task automatic look();
        ev_t e;
        @(negedge clk);
        if (bus.DATA_put === 1'b1) begin
            data_puts++;
            chk("data_put_while_full", bus.DATA_full, 1'b0);
            if (expq.size() == 0 || expq[0].kind != 2'd0) begin
                total++; bad++;
                $display("FAIL data_order: unexpected DATA_put %h, want none", bus.DATA_data_in);
            end else begin
                e = expq.pop_front();
                chk("data_word", bus.DATA_data_in, e.val);
            end
        end
        if (bus.CMD_put === 1'b1) begin
            chk("cmd_put_while_full", bus.CMD_full, 1'b0);
            if (expq.size() == 0 || expq[0].kind != 2'd1) begin
                total++; bad++;
                $display("FAIL cmd_order: unexpected CMD_put %h, want none", bus.CMD_data_in);
            end else begin
                e = expq.pop_front();
                chk("cmd_word", bus.CMD_data_in, e.val);
            end
        end
        if (bus.cmd_err === 1'b1) begin
            if (expq.size() == 0 || expq[0].kind != 2'd2) begin
                total++; bad++;
                $display("FAIL err_order: unexpected cmd_err=1, want 0");
            end else begin
                e = expq.pop_front();
                total++;
            end
        end
    endtask

    // Drive point, 1 time unit after the active edge.
    task automatic adv();
        @(posedge clk);
        #1;
        if (rand_full) begin
            bus.CMD_full  = ($urandom_range(0, 3) == 0);
            bus.DATA_full = ($urandom_range(0, 3) == 0);
        end
    endtask

    // Request-level expectation: write data, then {cmd, addr, tag}; bad code -> one error pulse.
    task automatic model_txn(input logic [2:0] c, input logic [25:0] a);
        if (c == 3'b010) begin
            for (int i = 0; i < 8; i++) expq.push_back('{2'd0, {18'd0, beats[i]}});
        end
        if (c == 3'b001 || c == 3'b010) begin
            expq.push_back('{2'd1, {c, a, 5'(model_tag)}});
            model_tag = (model_tag + 1) % 32;
        end else begin
            expq.push_back('{2'd2, 34'd0});
        end
    endtask

    task automatic accept(input logic [2:0] c, input logic [25:0] a);
        bit ok = 0;
        bus.host_valid = 1'b1;
        bus.host_cmd   = c;
        bus.host_addr  = a;
        for (int k = 0; k < 200 && !ok; k++) begin
            look();
            if (bus.host_ready === 1'b1) ok = 1;
            adv();
        end
        bus.host_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout: host_ready never 1 within 200 cycles");
        end
    endtask

    task automatic send_beats(input bit gaps);
        int i = 0;
        for (int k = 0; k < 400 && i < 8; k++) begin
            bus.host_wvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.host_wdata  = beats[i];
            look();
            if (bus.host_wvalid && bus.host_wready === 1'b1) i++;
            adv();
        end
        bus.host_wvalid = 1'b0;
        if (i != 8) begin
            total++; bad++;
            $display("FAIL beat_timeout: %0d beats accepted, want 8", i);
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            look();
            done = (bus.busy === 1'b0);
            adv();
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL idle_timeout: busy still 1 after 200 cycles, want 0");
        end
    endtask

    task automatic run_txn(input logic [2:0] c, input logic [25:0] a, input bit gaps);
        model_txn(c, a);
        accept(c, a);
        if (c == 3'b010) send_beats(gaps);
        wait_idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.host_valid  = 1'b0;
        bus.host_wvalid = 1'b0;
        bus.CMD_full    = 1'b0;
        bus.DATA_full   = 1'b0;
        look(); adv();
        look(); adv();
        reset = 1'b0;
        model_tag = 0;
        expq.delete();
    endtask

    task automatic chk_all_zero(input string tagname);
        chk({tagname, "_host_ready"},   bus.host_ready, 1'b0);
        chk({tagname, "_host_wready"},  bus.host_wready, 1'b0);
        chk({tagname, "_CMD_put"},      bus.CMD_put, 1'b0);
        chk({tagname, "_DATA_put"},     bus.DATA_put, 1'b0);
        chk({tagname, "_cmd_err"},      bus.cmd_err, 1'b0);
        chk({tagname, "_busy"},         bus.busy, 1'b0);
        chk({tagname, "_CMD_data_in"},  bus.CMD_data_in, 34'd0);
        chk({tagname, "_DATA_data_in"}, bus.DATA_data_in, 34'd0);
    endtask

    initial begin
        int d0;
        int tag_before;
        logic [33:0] w;
        logic [2:0]  c;
        logic [25:0] a;
        logic [2:0]  bad_codes [6];

        vt[0] = '{3'b001, 26'h0000001, 1'b1, 1'b0, 1'b0, {3'b001, 26'h0000001, 5'd0}};
        vt[1] = '{3'b010, 26'h3FFFFFF, 1'b0, 1'b0, 1'b1, {3'b010, 26'h3FFFFFF, 5'd1}};
        vt[2] = '{3'b111, 26'h0000000, 1'b0, 1'b1, 1'b0, 34'd0};
        vt[3] = '{3'b000, 26'h1111111, 1'b0, 1'b1, 1'b0, 34'd0};
        vt[4] = '{3'b001, 26'h2000000, 1'b1, 1'b0, 1'b0, {3'b001, 26'h2000000, 5'd2}};
        vt[5] = '{3'b011, 26'h0FFFFFF, 1'b0, 1'b1, 1'b0, 34'd0};
        vt[6] = '{3'b010, 26'h1234567, 1'b0, 1'b0, 1'b1, {3'b010, 26'h1234567, 5'd3}};
        vt[7] = '{3'b001, 26'h0ABCDEF, 1'b1, 1'b0, 1'b0, {3'b001, 26'h0ABCDEF, 5'd4}};
        bad_codes[0] = 3'b000; bad_codes[1] = 3'b011; bad_codes[2] = 3'b100;
        bad_codes[3] = 3'b101; bad_codes[4] = 3'b110; bad_codes[5] = 3'b111;

        // Reset with active-looking inputs: every output must read 0.
        reset = 1'b1;
        bus.host_valid  = 1'b1;
        bus.host_cmd    = 3'b001;
        bus.host_addr   = 26'h3FFFFFF;
        bus.host_wvalid = 1'b1;
        bus.host_wdata  = 16'hFFFF;
        bus.CMD_full    = 1'b0;
        bus.DATA_full   = 1'b0;
        look();
        chk_all_zero("reset");
        adv();
        do_reset();

        // SCR: command pushed the cycle after acceptance, tag 0.
        model_txn(3'b001, 26'h2A55A5A);
        accept(3'b001, 26'h2A55A5A);
        look();
        chk("scr_cmd_put", bus.CMD_put, 1'b1);
        chk("scr_cmd_word", bus.CMD_data_in, {3'b001, 26'h2A55A5A, 5'd0});
        chk("scr_no_data_put", bus.DATA_put, 1'b0);
        adv();
        look();
        chk("scr_done_cmd_put", bus.CMD_put, 1'b0);
        chk("scr_done_busy", bus.busy, 1'b0);
        adv();

        // SCW with 8 back-to-back beats, then exactly one command.
        for (int i = 0; i < 8; i++) beats[i] = 16'h1000 + 16'(i);
        model_txn(3'b010, 26'h0001234);
        accept(3'b010, 26'h0001234);
        for (int i = 0; i < 8; i++) begin
            bus.host_wvalid = 1'b1;
            bus.host_wdata  = beats[i];
            look();
            chk("scw_beat_put", bus.DATA_put, 1'b1);
            chk("scw_beat_word", bus.DATA_data_in, beats[i]);
            adv();
        end
        bus.host_wvalid = 1'b0;
        look();
        chk("scw_cmd_put", bus.CMD_put, 1'b1);
        chk("scw_cmd_code", bus.CMD_data_in[33:31], 3'b010);
        adv();
        look();
        chk("scw_single_cmd", bus.CMD_put, 1'b0);
        adv();

        // SCW with DATA_full high for three cycles mid-burst.
        for (int i = 0; i < 8; i++) beats[i] = 16'h2000 + 16'(i * 3);
        d0 = data_puts;
        model_txn(3'b010, 26'h2222222);
        accept(3'b010, 26'h2222222);
        bus.host_wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.host_wdata = beats[i];
            look(); adv();
        end
        bus.DATA_full  = 1'b1;
        bus.host_wdata = beats[3];
        for (int k = 0; k < 3; k++) begin
            look();
            chk("stall_wready", bus.host_wready, 1'b0);
            chk("stall_data_put", bus.DATA_put, 1'b0);
            adv();
        end
        bus.DATA_full = 1'b0;
        for (int i = 3; i < 8; i++) begin
            bus.host_wdata = beats[i];
            look();
            chk("resume_data_put", bus.DATA_put, 1'b1);
            adv();
        end
        bus.host_wvalid = 1'b0;
        wait_idle();
        chk("stall_total_beats", 34'(data_puts - d0), 34'd8);

        // CMD_full held for 10 cycles in PUSH.
        w = {3'b001, 26'h1555555, 5'(model_tag)};
        model_txn(3'b001, 26'h1555555);
        accept(3'b001, 26'h1555555);
        bus.CMD_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            look();
            chk("cmdfull_cmd_put", bus.CMD_put, 1'b0);
            chk("cmdfull_busy", bus.busy, 1'b1);
            adv();
        end
        bus.CMD_full = 1'b0;
        look();
        chk("cmdfull_release_put", bus.CMD_put, 1'b1);
        chk("cmdfull_release_word", bus.CMD_data_in, w);
        adv();

        // Invalid code: one error pulse, no writes, tag preserved.
        tag_before = model_tag;
        model_txn(3'b101, 26'h0F0F0F0);
        accept(3'b101, 26'h0F0F0F0);
        look();
        chk("err_pulse", bus.cmd_err, 1'b1);
        chk("err_no_cmd_put", bus.CMD_put, 1'b0);
        chk("err_no_data_put", bus.DATA_put, 1'b0);
        adv();
        look();
        chk("err_pulse_end", bus.cmd_err, 1'b0);
        chk("err_idle", bus.busy, 1'b0);
        adv();
        w = {3'b001, 26'h0000ABC, 5'(tag_before)};
        model_txn(3'b001, 26'h0000ABC);
        accept(3'b001, 26'h0000ABC);
        look();
        chk("err_next_tag", bus.CMD_data_in, w);
        adv();
        wait_idle();

        // Vector table from a fresh reset (tags start at 0).
        do_reset();
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 8; i++) beats[i] = 16'hA000 + 16'(v * 16 + i);
            model_txn(vt[v].cmd, vt[v].addr);
            accept(vt[v].cmd, vt[v].addr);
            look();
            chk("vec_cmd_put", bus.CMD_put, vt[v].exp_cmd_put);
            chk("vec_cmd_err", bus.cmd_err, vt[v].exp_err);
            chk("vec_wready", bus.host_wready, vt[v].exp_wready);
            if (vt[v].exp_cmd_put) chk("vec_cmd_word", bus.CMD_data_in, vt[v].exp_word);
            adv();
            if (vt[v].cmd == 3'b010) begin
                send_beats(1'b0);
                look();
                chk("vec_scw_cmd_put", bus.CMD_put, 1'b1);
                chk("vec_scw_cmd_word", bus.CMD_data_in, vt[v].exp_word);
                adv();
            end
            wait_idle();
        end

        // 33 reads: tags 0..31 then wrap to 0.
        do_reset();
        for (int i = 0; i < 33; i++) run_txn(3'b001, 26'(i * 26'h0031337), 1'b0);

        // Reset after 4 beats of a write burst.
        for (int i = 0; i < 8; i++) beats[i] = 16'h3000 + 16'(i);
        for (int i = 0; i < 4; i++) expq.push_back('{2'd0, {18'd0, beats[i]}});
        accept(3'b010, 26'h3333333);
        bus.host_wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.host_wdata = beats[i];
            look(); adv();
        end
        reset = 1'b1;
        bus.host_valid = 1'b1;
        bus.host_cmd   = 3'b001;
        look();
        chk_all_zero("midreset");
        adv();
        reset = 1'b0;
        bus.host_valid  = 1'b0;
        bus.host_wvalid = 1'b0;
        model_tag = 0;
        look();
        chk("midreset_busy", bus.busy, 1'b0);
        chk("midreset_idle_ready", bus.host_ready, 1'b1);
        chk("midreset_wready", bus.host_wready, 1'b0);
        chk("midreset_pending", 34'(expq.size()), 34'd0);
        adv();

        // Randomized traffic with random FIFO back-pressure.
        rand_full = 1;
        for (int n = 0; n < 40; n++) begin
            int r = $urandom_range(0, 7);
            if (r < 3)      c = 3'b001;
            else if (r < 6) c = 3'b010;
            else            c = bad_codes[$urandom_range(0, 5)];
            a = 26'($urandom);
            for (int i = 0; i < 8; i++) beats[i] = 16'($urandom);
            run_txn(c, a, 1'b1);
        end
        rand_full = 0;
        bus.CMD_full  = 1'b0;
        bus.DATA_full = 1'b0;
        look(); adv();
        chk("final_pending_events", 34'(expq.size()), 34'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
